// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 controller owning the cipher state register, fetching round
// keys over req/valid and applying AddRoundKey around an external combinational round datapath.
module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk_data,
    output logic [127:0] dp_state,
    output logic         dp_final,
    input  logic [127:0] dp_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    input  logic         flush,
    output logic         busy,
    output logic [3:0]   round
);
    typedef enum logic [1:0] {IDLE, KEY0, ROUND, DONE} state_t;
    state_t state, state_nx;
    logic [127:0] sreg, sreg_nx;
    logic [3:0] rnd, rnd_nx;
    logic last;
    assign last = rnd == 4'(NR);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sreg <= '0;
            rnd <= '0;
        end else begin
            state <= state_nx;
            sreg <= sreg_nx;
            rnd <= rnd_nx;
        end
    end
    // flush overrides every handshake; the state register is deliberately left as is
    always_comb begin
        state_nx = state;
        sreg_nx = sreg;
        rnd_nx = rnd;
        if (flush) begin
            state_nx = IDLE;
            rnd_nx = '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state_nx = KEY0;
                    sreg_nx = data_in;
                    rnd_nx = '0;
                end
                KEY0: if (rk_valid) begin
                    state_nx = ROUND;
                    sreg_nx = sreg ^ rk_data;
                    rnd_nx = 4'd1;
                end
                ROUND: if (rk_valid) begin
                    state_nx = last ? DONE : ROUND;
                    sreg_nx = dp_result ^ rk_data;
                    rnd_nx = last ? rnd : rnd + 4'd1;
                end
                DONE: if (out_ready) begin
                    state_nx = IDLE;
                    rnd_nx = '0;
                end
            endcase
        end
    end
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign rk_req = state == KEY0 || state == ROUND;
    assign rk_idx = state == ROUND ? rnd : 4'd0;
    assign dp_final = state == ROUND && last;
    assign out_valid = state == DONE;
    assign dp_state = sreg;
    assign data_out = sreg;
    assign round = rnd;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: drives the sequencer with a behavioural AES round datapath and key store,
// comparing ciphertext, latency and handshake behaviour against a plain software AES model.
module tb_aes_round_sequencer;
    localparam int NR = 10;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, rk_req, rk_valid, dp_final, out_valid, out_ready, flush, busy;
    logic [127:0] data_in, rk_data, dp_state, dp_result, data_out;
    logic [3:0] rk_idx, round;
    logic [127:0] rkeys [16];
    logic aes_dp;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_sequencer #(.NR(NR)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_data(rk_data),
        .dp_state(dp_state), .dp_final(dp_final), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .flush(flush), .busy(busy), .round(round)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: x^254 is the GF(2^8) inverse, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, r, s, t;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        s = r;
        t = r;
        for (int i = 0; i < 4; i++) begin
            t = {t[6:0], t[7]};
            s ^= t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0] b [4][4];
        logic [7:0] m;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                m = xt(b[r][c]) ^ xt(b[(r + 1) % 4][c]) ^ b[(r + 1) % 4][c] ^ b[(r + 2) % 4][c] ^ b[(r + 3) % 4][c];
                o[127 - 8 * (4 * c + r) -: 8] = fin ? b[r][c] : m;
            end
        return o;
    endfunction

    assign rk_data = rkeys[rk_idx];
    assign dp_result = aes_dp ? aes_round(dp_state, dp_final) : dp_state;

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int k = 0; k <= NR; k++) rkeys[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
    endtask

    function automatic logic [127:0] ref_cipher(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rkeys[0];
        for (int r = 1; r <= NR; r++) s = (aes_dp ? aes_round(s, r == NR) : s) ^ rkeys[r];
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts in an IDLE cycle (#1 after an edge) and returns in the IDLE cycle after the handshake.
    task automatic run_block(input logic [127:0] pt, input int stall_at, input int stall_n, input int hold_n,
                             output int lat, output logic [127:0] res, output int idx_cnt,
                             output logic held, output logic hold_ok, output logic hs_ok);
        int stalled;
        logic [127:0] snap;
        lat = -1; res = '0; idx_cnt = 0; held = 1'b1; hold_ok = 1'b1; hs_ok = 1'b0; stalled = 0; snap = '0;
        in_valid = 1'b1; data_in = pt; rk_valid = 1'b1; out_ready = 1'b0;
        for (int c = 1; c < 60; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
            rk_valid = 1'b1;
            if (stall_at >= 0 && rk_req && rk_idx == 4'(stall_at)) begin
                if (idx_cnt == 0) snap = dp_state;
                else if (dp_state !== snap) held = 1'b0;
                idx_cnt++;
                if (stalled < stall_n) begin
                    rk_valid = 1'b0;
                    stalled++;
                end
            end
        end
        if (lat < 0) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            return;
        end
        res = data_out;
        for (int h = 0; h < hold_n; h++) begin
            in_valid = 1'b1; data_in = ~pt;
            @(posedge clk); #1;
            if (!out_valid || data_out !== res || in_ready || !busy) hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        hs_ok = !out_valid && in_ready && !busy && round == 4'd0;
    endtask

    task automatic test_reset();
        n_chk++; if ({in_ready, out_valid, rk_req, busy, dp_final} !== 5'b10000) begin n_fail++; $display("FAIL reset_flags got %b want 10000", {in_ready, out_valid, rk_req, busy, dp_final}); end
        n_chk++; if ({rk_idx, round} !== 8'h00) begin n_fail++; $display("FAIL reset_idx_round got %h want 00", {rk_idx, round}); end
        n_chk++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out got %h want 0", data_out); end
        reset = 1'b0;
        in_valid = 1'b1; data_in = rnd128(); rk_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 20 && round != 4'd4; c++) begin @(posedge clk); #1; end
        n_chk++; if (round !== 4'd4 || !busy) begin n_fail++; $display("FAIL reset_reach_round got %0d busy %b want 4 busy 1", round, busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({in_ready, busy, out_valid, rk_req} !== 4'b1000) begin n_fail++; $display("FAIL reset_mid_flags got %b want 1000", {in_ready, busy, out_valid, rk_req}); end
        n_chk++; if (round !== 4'd0 || data_out !== '0) begin n_fail++; $display("FAIL reset_mid_state got round %0d data %h want 0 0", round, data_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stub();
        int lat, ic;
        logic [127:0] res;
        logic held, hok, hs;
        aes_dp = 1'b0;
        for (int i = 0; i < 16; i++) rkeys[i] = {16{4'h0, 4'(i)}};
        run_block('0, -1, 0, 0, lat, res, ic, held, hok, hs);
        n_chk++; if (lat !== 12) begin n_fail++; $display("FAIL stub_latency got %0d want 12", lat); end
        n_chk++; if (res !== {16{8'h0b}}) begin n_fail++; $display("FAIL stub_data got %h want %h", res, {16{8'h0b}}); end
        n_chk++; if (!hs) begin n_fail++; $display("FAIL stub_handshake got 0 want 1"); end
    endtask

    task automatic test_known_vector();
        int lat, ic;
        logic [127:0] res;
        logic held, hok, hs;
        aes_dp = 1'b1;
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        run_block(128'h00112233445566778899aabbccddeeff, -1, 0, 0, lat, res, ic, held, hok, hs);
        n_chk++; if (res !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_fail++; $display("FAIL fips197_data got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", res); end
        n_chk++; if (lat !== 12) begin n_fail++; $display("FAIL fips197_latency got %0d want 12", lat); end
    endtask

    task automatic test_stall();
        int lat, ic;
        logic [127:0] res, pt;
        logic held, hok, hs;
        pt = rnd128();
        run_block(pt, 5, 3, 0, lat, res, ic, held, hok, hs);
        n_chk++; if (lat !== 15) begin n_fail++; $display("FAIL stall_latency got %0d want 15", lat); end
        n_chk++; if (ic !== 4) begin n_fail++; $display("FAIL stall_idx_hold got %0d cycles at idx 5 want 4", ic); end
        n_chk++; if (!held) begin n_fail++; $display("FAIL stall_state_held got 0 want 1"); end
        n_chk++; if (res !== ref_cipher(pt)) begin n_fail++; $display("FAIL stall_data got %h want %h", res, ref_cipher(pt)); end
    endtask

    task automatic test_out_hold();
        int lat, ic;
        logic [127:0] res, pt;
        logic held, hok, hs;
        pt = rnd128();
        run_block(pt, -1, 0, 4, lat, res, ic, held, hok, hs);
        n_chk++; if (!hok) begin n_fail++; $display("FAIL hold_stable got 0 want 1"); end
        n_chk++; if (!hs) begin n_fail++; $display("FAIL hold_handshake_idle got 0 want 1"); end
        n_chk++; if (res !== ref_cipher(pt)) begin n_fail++; $display("FAIL hold_data got %h want %h", res, ref_cipher(pt)); end
    endtask

    task automatic test_flush();
        int lat, ic;
        logic [127:0] res, pt, snap;
        logic held, hok, hs;
        load_key(rnd128());
        in_valid = 1'b1; data_in = rnd128(); rk_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 30 && !(rk_req && rk_idx == 4'd7); c++) begin @(posedge clk); #1; end
        n_chk++; if (rk_idx !== 4'd7) begin n_fail++; $display("FAIL flush_reach_round got %0d want 7", rk_idx); end
        snap = dp_state;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_chk++; if ({in_ready, busy, rk_req, out_valid} !== 4'b1000 || round !== 4'd0) begin n_fail++; $display("FAIL flush_idle got %b round %0d want 1000 round 0", {in_ready, busy, rk_req, out_valid}, round); end
        n_chk++; if (dp_state !== snap) begin n_fail++; $display("FAIL flush_state_kept got %h want %h", dp_state, snap); end
        pt = rnd128();
        run_block(pt, -1, 0, 0, lat, res, ic, held, hok, hs);
        n_chk++; if (lat !== 12 || res !== ref_cipher(pt)) begin n_fail++; $display("FAIL flush_next_block got lat %0d data %h want 12 %h", lat, res, ref_cipher(pt)); end
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_beats_in_valid got busy %b want 0", busy); end
        in_valid = 1'b1; data_in = rnd128();
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 30 && !out_valid; c++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_chk++; if ({out_valid, busy, in_ready} !== 3'b001) begin n_fail++; $display("FAIL flush_in_done got %b want 001", {out_valid, busy, in_ready}); end
    endtask

    task automatic test_back_to_back();
        int l0, l1, ic, s0, s1;
        logic [127:0] r0, r1, pa, pb;
        logic held, hok, hs;
        pa = rnd128(); pb = rnd128();
        s0 = cyc;
        run_block(pa, -1, 0, 0, l0, r0, ic, held, hok, hs);
        s1 = cyc;
        run_block(pb, -1, 0, 0, l1, r1, ic, held, hok, hs);
        n_chk++; if (s1 - s0 !== NR + 3) begin n_fail++; $display("FAIL b2b_period got %0d want %0d", s1 - s0, NR + 3); end
        n_chk++; if (r0 !== ref_cipher(pa) || r1 !== ref_cipher(pb)) begin n_fail++; $display("FAIL b2b_data got %h %h want %h %h", r0, r1, ref_cipher(pa), ref_cipher(pb)); end
        n_chk++; if (l1 !== 12) begin n_fail++; $display("FAIL b2b_latency got %0d want 12", l1); end
    endtask

    task automatic test_random();
        int lat, ic, sa, sn, hn;
        logic [127:0] res, pt, exp_ct;
        logic held, hok, hs;
        for (int it = 0; it < 6; it++) begin
            aes_dp = 1'($urandom_range(0, 1));
            if (aes_dp) load_key(rnd128());
            else for (int i = 0; i < 16; i++) rkeys[i] = rnd128();
            pt = rnd128();
            sa = $urandom_range(0, NR); sn = $urandom_range(0, 3); hn = $urandom_range(0, 3);
            exp_ct = ref_cipher(pt);
            run_block(pt, sa, sn, hn, lat, res, ic, held, hok, hs);
            n_chk++; if (res !== exp_ct) begin n_fail++; $display("FAIL rand%0d_data got %h want %h", it, res, exp_ct); end
            n_chk++; if (lat !== 12 + sn) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, 12 + sn); end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; rk_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        data_in = '0; aes_dp = 1'b0;
        for (int i = 0; i < 16; i++) rkeys[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_stub();
        test_known_vector();
        test_stall();
        test_out_hold();
        test_flush();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
